// File: rtl/key_shift_in.sv
// Serial reader for a 74HC165-style PISO chain: parallel-load, then clock NBIT bits in MSB first.
// Optional KEY_SHIFT_IN_SYNC_EN adds a 2-flop synchronizer on sft_q7 and lengthens each low phase by 2 cycles.
module key_shift_in #(
   parameter int NBIT    = 8,
   parameter int CP_HALF = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vld,
   output logic [NBIT-1:0] dout,
   output logic            done,
   output logic            busy,
   output logic            sft_pl_n,
   output logic            sft_cp,
   input  logic            sft_q7
);

   localparam int BW = $clog2(NBIT) + 1;
   localparam int PW = 5;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t          r_state;
   logic [NBIT-1:0] r_shreg;
   logic [NBIT-1:0] r_dout;
   logic [BW-1:0]   r_bit_cnt;
   logic [PW-1:0]   r_ph_cnt;
   logic            r_high;
   logic            r_done;
   logic            r_busy;
   logic            r_pl_n;
   logic            r_cp;
   logic            w_sample;

`ifdef KEY_SHIFT_IN_SYNC_EN
   localparam int LOW_LEN = CP_HALF + 2;
   logic [1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= 2'b00;
      else     r_sync <= {r_sync[0], sft_q7};
   end
   assign w_sample = r_sync[1];
`else
   localparam int LOW_LEN = CP_HALF;
   assign w_sample = sft_q7;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_dout    <= '0;
         r_bit_cnt <= '0;
         r_ph_cnt  <= '0;
         r_high    <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_pl_n    <= 1'b1;
         r_cp      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (vld) begin
                  r_state  <= S_LOAD;
                  r_busy   <= 1'b1;
                  r_pl_n   <= 1'b0;
                  r_ph_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (r_ph_cnt == PW'(1)) begin
                  r_state   <= S_SHIFT;
                  r_pl_n    <= 1'b1;
                  r_ph_cnt  <= '0;
                  r_high    <= 1'b0;
                  r_bit_cnt <= '0;
               end else begin
                  r_ph_cnt <= r_ph_cnt + PW'(1);
               end
            end
            S_SHIFT: begin
               // Q7 is stable through the low phase; capture it just before the rising sft_cp.
               if (!r_high) begin
                  if (r_ph_cnt == PW'(LOW_LEN - 1)) begin
                     r_shreg   <= {r_shreg[NBIT-2:0], w_sample};
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                     r_high    <= 1'b1;
                     r_cp      <= 1'b1;
                     r_ph_cnt  <= '0;
                  end else begin
                     r_ph_cnt <= r_ph_cnt + PW'(1);
                  end
               end else begin
                  if (r_ph_cnt == PW'(CP_HALF - 1)) begin
                     r_ph_cnt <= '0;
                     r_high   <= 1'b0;
                     r_cp     <= 1'b0;
                     if (r_bit_cnt == BW'(NBIT)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_dout  <= r_shreg;
                     end
                  end else begin
                     r_ph_cnt <= r_ph_cnt + PW'(1);
                  end
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_bit_cnt <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dout     = r_dout;
   assign done     = r_done;
   assign busy     = r_busy;
   assign sft_pl_n = r_pl_n;
   assign sft_cp   = r_cp;

endmodule

// File: tb/tb_key_shift_in.sv
// Directed bench for key_shift_in: two instances (8-bit/CP_HALF=1 and 12-bit/CP_HALF=3), each fed by a 74HC165 model.
module tb_key_shift_in;

`ifdef KEY_SHIFT_IN_SYNC_EN
   localparam int EXP_DONE8  = 35;
   localparam int EXP_LOW8   = 24;
   localparam int EXP_DONE12 = 99;
   localparam int EXP_LOW12  = 60;
`else
   localparam int EXP_DONE8  = 19;
   localparam int EXP_LOW8   = 8;
   localparam int EXP_DONE12 = 75;
   localparam int EXP_LOW12  = 36;
`endif

   logic        clk;
   logic        rst;
   logic        vld8, vld12;
   logic [7:0]  dout8;
   logic [11:0] dout12;
   logic        done8, busy8, pl8, cp8, q7_8;
   logic        done12, busy12, pl12, cp12, q7_12;
   logic [7:0]  load8, ext8;
   logic [11:0] load12, ext12;

   int n_checks = 0;
   int n_err    = 0;

   key_shift_in #(.NBIT(8), .CP_HALF(1)) u_dut8 (
      .clk(clk), .rst(rst), .vld(vld8), .dout(dout8), .done(done8), .busy(busy8),
      .sft_pl_n(pl8), .sft_cp(cp8), .sft_q7(q7_8)
   );

   key_shift_in #(.NBIT(12), .CP_HALF(3)) u_dut12 (
      .clk(clk), .rst(rst), .vld(vld12), .dout(dout12), .done(done12), .busy(busy12),
      .sft_pl_n(pl12), .sft_cp(cp12), .sft_q7(q7_12)
   );

   // External PISO registers: load while PL low, shift toward Q7 on rising CP.
   always @(negedge pl8 or posedge cp8) begin
      if (!pl8) ext8 <= load8;
      else      ext8 <= {ext8[6:0], 1'b0};
   end
   assign q7_8 = ext8[7];

   always @(negedge pl12 or posedge cp12) begin
      if (!pl12) ext12 <= load12;
      else       ext12 <= {ext12[10:0], 1'b0};
   end
   assign q7_12 = ext12[11];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Starts at a negedge with vld asserted in that cycle; returns at the negedge of the done cycle.
   task automatic read_xfer(input bit sel, input logic [15:0] pat, input bit inject,
                            output int dcyc, output int pulses, output int plc,
                            output int lowc, output int highc, output logic [15:0] mid,
                            output logic [15:0] res);
      int   c;
      logic prev;
      logic s_pl, s_cp, s_busy, s_done;
      dcyc = -1; pulses = 0; plc = 0; lowc = 0; highc = 0; mid = '0; res = '0;
      prev = 1'b0;
      if (sel) begin load12 = pat[11:0]; vld12 = 1'b1; end
      else     begin load8  = pat[7:0];  vld8  = 1'b1; end
      @(negedge clk);
      vld8 = 1'b0; vld12 = 1'b0;
      c = 1;
      while (c < 300) begin
         if (!sel) vld8 = inject && (c == 5 || c == 19);
         s_pl   = sel ? pl12   : pl8;
         s_cp   = sel ? cp12   : cp8;
         s_busy = sel ? busy12 : busy8;
         s_done = sel ? done12 : done8;
         if (!s_pl) plc++;
         if (s_busy && s_pl && !s_done) begin
            if (s_cp) highc++;
            else      lowc++;
         end
         if (s_cp && !prev) pulses++;
         prev = s_cp;
         if (c == 10) mid = sel ? {4'h0, dout12} : {8'h00, dout8};
         if (s_done) begin
            dcyc = c;
            res  = sel ? {4'h0, dout12} : {8'h00, dout8};
            break;
         end
         c++;
         @(negedge clk);
      end
      $display("read inst=%0d pattern=0x%0h done_cycle=%0d dout=0x%0h cp_pulses=%0d", sel ? 12 : 8, pat, dcyc, res, pulses);
   endtask

   int          dcyc, pulses, plc, lowc, highc, ndone;
   logic [15:0] mid, res;

   initial begin
      rst = 1'b1; vld8 = 1'b0; vld12 = 1'b0; load8 = '0; load12 = '0;
      repeat (3) @(negedge clk);
      vld8 = 1'b1;
      @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_dout", dout8, 0);
      check("rst_pl_n", pl8, 1);
      check("rst_cp", cp8, 0);
      rst = 1'b0; vld8 = 1'b0;
      @(negedge clk);
      check("idle_busy", busy8, 0);

      read_xfer(0, 16'h00A5, 0, dcyc, pulses, plc, lowc, highc, mid, res);
      check("a5_done_cyc", dcyc, EXP_DONE8);
      check("a5_dout", res, 16'h00A5);
      check("a5_pulses", pulses, 8);
      check("a5_pl_low", plc, 2);
      check("a5_low_cyc", lowc, EXP_LOW8);
      check("a5_high_cyc", highc, 8);

      @(negedge clk);
      read_xfer(0, 16'h003C, 1, dcyc, pulses, plc, lowc, highc, mid, res);
      check("inj_done_cyc", dcyc, EXP_DONE8);
      check("inj_dout", res, 16'h003C);
      @(negedge clk);
      check("inj_ignored_busy", busy8, 0);
      check("done_one_cycle", done8, 0);
      read_xfer(0, 16'h005A, 0, dcyc, pulses, plc, lowc, highc, mid, res);
      check("c20_done_cyc", dcyc, EXP_DONE8);
      check("c20_dout", res, 16'h005A);
      check("c20_hold_prev", mid, 16'h003C);

      @(negedge clk);
      read_xfer(0, 16'h0000, 0, dcyc, pulses, plc, lowc, highc, mid, res);
      check("b2b0_dout", res, 16'h0000);
      check("b2b0_done_cyc", dcyc, EXP_DONE8);
      @(negedge clk);
      read_xfer(0, 16'h00FF, 0, dcyc, pulses, plc, lowc, highc, mid, res);
      check("b2b1_hold", mid, 16'h0000);
      check("b2b1_dout", res, 16'h00FF);

      @(negedge clk);
      read_xfer(1, 16'h0C3A, 0, dcyc, pulses, plc, lowc, highc, mid, res);
      check("w12_done_cyc", dcyc, EXP_DONE12);
      check("w12_dout", res, 16'h0C3A);
      check("w12_pulses", pulses, 12);
      check("w12_pl_low", plc, 2);
      check("w12_low_cyc", lowc, EXP_LOW12);
      check("w12_high_cyc", highc, 36);
      check("w8_hold_dout", dout8, 8'hFF);

      // Abort a read of 0xFF with reset in cycle 10.
      @(negedge clk);
      load8 = 8'hFF; vld8 = 1'b1;
      @(negedge clk);
      vld8 = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", busy8, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy8, 0);
      check("abort_cp", cp8, 0);
      check("abort_pl_n", pl8, 1);
      check("abort_dout", dout8, 0);
      check("abort_done", done8, 0);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_dout_hold", dout8, 0);
      $display("read inst=8 pattern=0xff aborted by reset, dout=0x%0h", dout8);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
